// File: rtl/input_cal.sv
// input_cal: per-channel offset/gain calibration of four codec samples.
// One shared subtract/multiply/round pipeline is time-multiplexed over the
// four channels; results collect in shadow registers and are published
// together with a single-cycle sample_valid pulse.
module input_cal #(
  parameter int                 W       = 16,
  parameter logic signed [W-1:0] OFFSET0 = '0,
  parameter logic signed [W-1:0] OFFSET1 = '0,
  parameter logic signed [W-1:0] OFFSET2 = '0,
  parameter logic signed [W-1:0] OFFSET3 = '0,
  parameter logic signed [15:0]  GAIN0   = 16'sd16384,
  parameter logic signed [15:0]  GAIN1   = 16'sd16384,
  parameter logic signed [15:0]  GAIN2   = 16'sd16384,
  parameter logic signed [15:0]  GAIN3   = 16'sd16384
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_clk,
  input  logic signed [W-1:0] sample_in0,
  input  logic signed [W-1:0] sample_in1,
  input  logic signed [W-1:0] sample_in2,
  input  logic signed [W-1:0] sample_in3,
  input  logic [7:0]          jack,
  output logic signed [W-1:0] sample_out0,
  output logic signed [W-1:0] sample_out1,
  output logic signed [W-1:0] sample_out2,
  output logic signed [W-1:0] sample_out3,
  output logic                sample_valid
);

  typedef enum logic [1:0] {IDLE, RUN, COMMIT} state_t;

  localparam int PW = W + 17;  // full product width

  localparam logic signed [W-1:0] OFFS  [4] = '{OFFSET0, OFFSET1, OFFSET2, OFFSET3};
  localparam logic signed [15:0]  GAINS [4] = '{GAIN0, GAIN1, GAIN2, GAIN3};

  localparam logic signed [PW-1:0] RND     = PW'(8192);
  localparam logic signed [PW-1:0] SAT_MAX = {{18{1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {{18{1'b1}}, {(W-1){1'b0}}};

  // Control state
  state_t              state_q, state_d;
  logic                sample_clk_d_q, sample_clk_d_d;  // delayed strobe for edge detect
  logic [2:0]          cnt_q, cnt_d;                    // next channel to issue
  logic                s1_vld_q, s1_vld_d;
  logic [1:0]          s1_ch_q, s1_ch_d;
  logic                s2_vld_q, s2_vld_d;
  logic [1:0]          s2_ch_q, s2_ch_d;
  logic [3:0]          jack_q, jack_d;
  logic signed [W-1:0] shadow_q [4];
  logic signed [W-1:0] shadow_d [4];
  logic signed [W-1:0] out_q [4];
  logic signed [W-1:0] out_d [4];
  logic                valid_q, valid_d;

  // Datapath registers
  logic signed [W-1:0]  snap_q [4];
  logic signed [W-1:0]  snap_d [4];
  logic signed [W:0]    diff_q, diff_d;
  logic signed [PW-1:0] prod_q, prod_d;

  // Stage-3 helpers
  logic signed [PW-1:0] rounded;
  logic signed [PW-1:0] shifted;
  logic signed [W-1:0]  sat_res;
  logic signed [PW-1:0] diff_ext;
  logic signed [PW-1:0] gain_ext;
  logic signed [W-1:0]  off_sel;
  logic signed [W-1:0]  in_sel;
  logic                 start;

  // Upper jack bits report output jacks, which play no part in calibration.
  logic unused_jack_hi;
  assign unused_jack_hi = ^jack[7:4];

  assign start = sample_clk & ~sample_clk_d_q;

  // Next-state, pipeline advance and commit logic.
  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    sample_clk_d_d = sample_clk;
    cnt_d          = cnt_q;
    s1_vld_d       = 1'b0;
    s1_ch_d        = s1_ch_q;
    s2_vld_d       = s1_vld_q;
    s2_ch_d        = s1_ch_q;
    jack_d         = jack_q;
    shadow_d       = shadow_q;
    out_d          = out_q;
    valid_d        = 1'b0;
    snap_d         = snap_q;
    diff_d         = diff_q;
    in_sel         = snap_q[cnt_q[1:0]];
    off_sel        = OFFS[cnt_q[1:0]];

    // Stage 2: full-precision multiply by the tagged channel's gain.
    diff_ext = {{16{diff_q[W]}}, diff_q};
    gain_ext = {{(W+1){GAINS[s1_ch_q][15]}}, GAINS[s1_ch_q]};
    prod_d   = diff_ext * gain_ext;

    // Stage 3: round half up, saturate, land in the channel's shadow.
    rounded = prod_q + RND;
    shifted = rounded >>> 14;
    if (shifted > SAT_MAX)      sat_res = SAT_MAX[W-1:0];
    else if (shifted < SAT_MIN) sat_res = SAT_MIN[W-1:0];
    else                        sat_res = shifted[W-1:0];
    if (s2_vld_q) shadow_d[s2_ch_q] = sat_res;

    case (state_q)
      IDLE: begin
        if (start) begin
          snap_d  = '{sample_in0, sample_in1, sample_in2, sample_in3};
          jack_d  = jack[3:0];
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Stage 1: issue one channel per cycle until all four are in flight.
        if (!cnt_q[2]) begin
          s1_vld_d = 1'b1;
          s1_ch_d  = cnt_q[1:0];
          diff_d   = {in_sel[W-1], in_sel} - {off_sel[W-1], off_sel};
          cnt_d    = cnt_q + 3'd1;
        end
        if (s2_vld_q && (s2_ch_q == 2'd3)) state_d = COMMIT;
      end
      COMMIT: begin
        for (int k = 0; k < 4; k++) begin
          out_d[k] = jack_q[k] ? shadow_q[k] : '0;
        end
        valid_d = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      sample_clk_d_q <= 1'b1;  // a strobe held high across release is not an edge
      cnt_q          <= '0;
      s1_vld_q       <= 1'b0;
      s1_ch_q        <= '0;
      s2_vld_q       <= 1'b0;
      s2_ch_q        <= '0;
      jack_q         <= '0;
      shadow_q       <= '{default: '0};
      out_q          <= '{default: '0};
      valid_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      sample_clk_d_q <= sample_clk_d_d;
      cnt_q          <= cnt_d;
      s1_vld_q       <= s1_vld_d;
      s1_ch_q        <= s1_ch_d;
      s2_vld_q       <= s2_vld_d;
      s2_ch_q        <= s2_ch_d;
      jack_q         <= jack_d;
      shadow_q       <= shadow_d;
      out_q          <= out_d;
      valid_q        <= valid_d;
    end
  end

  // Datapath registers.
  // NOTE: these carry no reset; their contents only matter when qualified
  // by the reset-cleared valid tags, so reset adds nothing but fan-out.
  always_ff @(posedge clk) begin
    snap_q <= snap_d;
    diff_q <= diff_d;
    prod_q <= prod_d;
  end

  assign sample_out0  = out_q[0];
  assign sample_out1  = out_q[1];
  assign sample_out2  = out_q[2];
  assign sample_out3  = out_q[3];
  assign sample_valid = valid_q;

endmodule

// File: doc/input_cal.md
INPUT_CAL -- requirements
Module: input_cal

Interface
REQ-001 The block SHALL have parameter W, default 16, meaning sample width in bits (signed two's complement).
REQ-002 The block SHALL have parameters OFFSET0..OFFSET3, default 0, meaning the signed W-bit raw ADC offset per channel.
REQ-003 The block SHALL have parameters GAIN0..GAIN3, default 16384, meaning the signed 16-bit Q2.14 gain per channel (16384 = 1.0).
REQ-004 The block SHALL have port clk, input, 1 bit: system clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port sample_clk, input, 1 bit: audio-rate strobe, synchronous to clk, high for at least 1 clk.
REQ-007 The block SHALL have ports sample_in0..sample_in3, input, W bits signed: raw codec samples.
REQ-008 The block SHALL have ports sample_out0..sample_out3, output, W bits signed, registered: calibrated samples feeding the downstream core.
REQ-009 The block SHALL have port jack, input, 8 bits: jack-detect; bits 0..3 = input jacks 0..3, 1 = plugged.
REQ-010 The block SHALL have port sample_valid, output, 1 bit: single-cycle pulse when sample_out0..3 update.

Function
REQ-011 The block SHALL register sample_clk into sample_clk_d each cycle; a start edge is sample_clk=1 and sample_clk_d=0 at clk edge N.
REQ-012 The block SHALL implement states IDLE, RUN, COMMIT; IDLE->RUN on start edge, RUN->COMMIT after last channel result, COMMIT->IDLE unconditionally after 1 cycle.
REQ-013 At edge N the block SHALL snapshot sample_in0..3 and jack[3:0] into internal registers; later input changes SHALL NOT affect this conversion.
REQ-014 In RUN the block SHALL process channels 0,1,2,3 in order, issuing one per cycle at edges N+1..N+4, through one shared subtract/multiply datapath.
REQ-015 Pipeline stage 1 SHALL compute diff = in - OFFSETk at W+1 bits with no overflow.
REQ-016 Pipeline stage 2 SHALL compute prod = diff * GAINk at full W+17-bit signed precision.
REQ-017 Pipeline stage 3 SHALL compute (prod + 8192) >>> 14 (arithmetic shift, round half up), saturate to [-2^(W-1), 2^(W-1)-1], and write the result into a shadow register for channel k.
REQ-018 The channel-3 result SHALL land in the shadow register at edge N+6.
REQ-019 In COMMIT (edge N+7) all four sample_out SHALL update simultaneously from the shadow registers, and sample_valid SHALL be 1 for exactly that one cycle.
REQ-020 At commit, a channel whose snapshotted jack bit is 0 SHALL output 0 regardless of its input.
REQ-021 Latency SHALL be fixed at 7 clk from start edge to output update; outputs SHALL hold between commits.
REQ-022 Start edges occurring in RUN or COMMIT SHALL be ignored and SHALL NOT be queued; sample_clk_d SHALL still track sample_clk.
REQ-023 A start edge in the same cycle the block returns to IDLE SHALL be accepted.
REQ-024 Shadow registers SHALL NOT be visible on sample_out except via COMMIT.

Reset
REQ-025 When rst=1 at a clk edge, the block SHALL set state to IDLE, sample_out0..3 to 0, sample_valid to 0, shadow registers to 0, and the channel counter to 0.
REQ-026 During reset, sample_clk_d SHALL be set to 1 so that a sample_clk held high across reset release does not start a conversion.
REQ-027 Reset asserted mid-RUN SHALL abort the conversion with no commit, no sample_valid pulse, and no partial output update.

Verification
REQ-028 Bench SHALL cover identity: defaults, jack=8'h0F, in0..3 = 1000,-1000,32767,-32768, one sample_clk pulse -> outputs equal inputs at N+7, exactly one sample_valid pulse.
REQ-029 Bench SHALL cover offset/gain: OFFSET0=100, GAIN0=8192, in0=1101 -> out0=501 (rounding), other channels unchanged.
REQ-030 Bench SHALL cover saturation: GAIN1=32767, OFFSET1=-20000, in1=30000 -> out1=32767; in1=-30000 with OFFSET1=20000 -> out1=-32768.
REQ-031 Bench SHALL cover jack masking: jack=8'h05, all inputs 5000 -> out0=out2=5000, out1=out3=0.
REQ-032 Bench SHALL cover overlap: second sample_clk rising edge at N+3 -> ignored, single commit at N+7; inputs changed at N+2 -> not reflected.
REQ-033 Bench SHALL cover reset: rst pulse at N+4 -> outputs remain 0, no sample_valid; sample_clk high through reset release -> no conversion until a fresh rising edge.
